// File: rtl/mips_trace_pkg.sv
// Shared types and defaults for the store trace monitor.
package mips_trace_pkg;

  localparam logic [31:0] DEF_DONE_ADDR = 32'h54;
  localparam logic [31:0] DEF_DONE_DATA = 32'h1;
  localparam int          TRACE_CYC_W   = 16;

  typedef struct packed {
    logic [TRACE_CYC_W-1:0] cycle;
    logic [31:0]            addr;
    logic [31:0]            data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  function automatic logic is_completion_store(input logic        we,
                                               input logic [31:0] adr,
                                               input logic [31:0] done_addr);
    return we && (adr == done_addr);
  endfunction

endpackage

// File: rtl/store_trace_monitor_if.sv
// Core store port plus trace drain stream; master drives stores and ready.
interface store_trace_monitor_if #(
  parameter int CYC_W = 16
) ();
  logic             memwrite;
  logic [31:0]      dataadr;
  logic [31:0]      writedata;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_addr;
  logic [31:0]      m_data;
  logic [CYC_W-1:0] m_cycle;

  modport master (
    output memwrite, dataadr, writedata, m_ready,
    input  m_valid, m_addr, m_data, m_cycle
  );

  modport slave (
    input  memwrite, dataadr, writedata, m_ready,
    output m_valid, m_addr, m_data, m_cycle
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO only lands when a pop frees the slot.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  entry_t      wr_entry,
  output entry_t      head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is not reset; flushing the pointers and count is enough.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_monitor.sv
// Captures core stores into a stamped trace FIFO and reports program completion.
// Optional watchdog enabled by defining STORE_TIMEOUT_EN.
//
//  state   | meaning
//  RUN     | program running, stores captured
//  PASS    | completion store carried DONE_DATA
//  FAIL    | completion store carried another value
//  TIMEOUT | watchdog expired before completion
module store_trace_monitor
  import mips_trace_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] DONE_ADDR   = DEF_DONE_ADDR,
  parameter logic [31:0] DONE_DATA   = DEF_DONE_DATA,
  parameter int          CYC_W       = TRACE_CYC_W,
  parameter int          TIMEOUT_CYC = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  store_trace_monitor_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout
);

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    logic [31:0]      addr;
    logic [31:0]      data;
  } entry_t;

  mon_state_t       state, state_next;
  logic [CYC_W-1:0] cycle;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             completion;
  entry_t           wr_entry;
  entry_t           head;

  assign push       = bus.memwrite && (state == RUN);
  assign pop        = bus.m_ready && !empty;
  assign completion = is_completion_store(bus.memwrite, bus.dataadr, DONE_ADDR);
  assign wr_entry   = '{cycle: cycle, addr: bus.dataadr, data: bus.writedata};

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (bus.m_ready),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign bus.m_valid = !empty;
  assign bus.m_addr  = head.addr;
  assign bus.m_data  = head.data;
  assign bus.m_cycle = head.cycle;

  // Saturating so late stores keep a monotonic, if clipped, stamp.
  always_ff @(posedge clk) begin
    if (!reset)             cycle <= '0;
    else if (cycle != '1)   cycle <= cycle + CYC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset)                      overflow <= 1'b0;
    else if (push && full && !pop)   overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (completion) begin
          state_next = (bus.writedata == DONE_DATA) ? PASS : FAIL;
        end
`ifdef STORE_TIMEOUT_EN
        else if (cycle >= CYC_W'(TIMEOUT_CYC)) begin
          state_next = TIMEOUT;
        end
`endif
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= (state_next != RUN);
      pass <= (state_next == PASS);
    end
  end

`ifdef STORE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) timeout <= 1'b0;
    else        timeout <= (state_next == TIMEOUT);
  end
`else
  assign timeout = 1'b0;
  wire unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule
